// File: rtl/boot_loader.sv
// Program-image loader for the NanoRisc core: parses a sync/length/payload/checksum byte frame,
// writes the payload into instruction memory from address 0 and releases the core on success.
module boot_loader #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  rx_valid,
  input  logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [DATA_WIDTH-1:0] imem_wdata,
  output logic                  core_run,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LEN  = 3'd1;
  localparam logic [2:0] ST_DATA = 3'd2;
  localparam logic [2:0] ST_CSUM = 3'd3;
  localparam logic [2:0] ST_RUN  = 3'd4;
  localparam logic [2:0] ST_ERR  = 3'd5;

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_LIMIT = TW'(TIMEOUT_CYCLES - 1);
  // A length byte of zero encodes a full 2**ADDR_WIDTH payload.
  localparam logic [ADDR_WIDTH:0] FULL_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [2:0]            state;
  logic [ADDR_WIDTH:0]   frame_len;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] acc;
  logic [TW-1:0]         timer;
  logic                  accept;
  logic                  in_frame;
  logic                  is_sync;
  logic [ADDR_WIDTH:0]   wl_next;

  assign rx_ready = (state != ST_RUN);
  assign core_run = (state == ST_RUN);
  assign error    = (state == ST_ERR);
  assign accept   = rx_valid && rx_ready;
  assign is_sync  = (rx_data == DATA_WIDTH'(SYNC_BYTE));
  assign in_frame = (state == ST_LEN) || (state == ST_DATA) || (state == ST_CSUM);
  assign wl_next  = words_loaded + {{ADDR_WIDTH{1'b0}}, 1'b1};

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_IDLE;
      frame_len    <= '0;
      addr         <= '0;
      acc          <= '0;
      timer        <= '0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      words_loaded <= '0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        ST_IDLE, ST_ERR: begin
          if (accept && is_sync) begin
            state <= ST_LEN;
            timer <= '0;
          end
        end
        ST_LEN: begin
          if (accept) begin
            frame_len    <= (rx_data == '0) ? FULL_LEN : (ADDR_WIDTH + 1)'(rx_data);
            acc          <= '0;
            addr         <= '0;
            words_loaded <= '0;
            state        <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (accept) begin
            imem_we      <= 1'b1;
            imem_addr    <= addr;
            imem_wdata   <= rx_data;
            addr         <= addr + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
            acc          <= acc + rx_data;
            words_loaded <= wl_next;
            if (wl_next == frame_len) state <= ST_CSUM;
          end
        end
        ST_CSUM: begin
          if (accept) state <= (rx_data == acc) ? ST_RUN : ST_ERR;
        end
        ST_RUN: ;
        default: state <= ST_IDLE;
      endcase

      // Inter-byte watchdog; an accepted byte always beats a simultaneous expiry.
      if (in_frame) begin
        if (accept) begin
          timer <= '0;
        end else if (timer == TIMER_LIMIT) begin
          timer <= '0;
          state <= ST_ERR;
        end else begin
          timer <= timer + TW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: frame loads, checksum error/recovery, 256-byte image,
// timeout, mid-frame reset and throttled input.
module tb_boot_loader;

  localparam int unsigned TIMEOUT = 1000;

  logic       clock = 1'b0;
  logic       reset;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       imem_we;
  logic [7:0] imem_addr;
  logic [7:0] imem_wdata;
  logic       core_run;
  logic       error;
  logic [8:0] words_loaded;

  int checks = 0;
  int errors = 0;

  // Write log captured from the memory port.
  int         wn = 0;
  int         cyc = 0;
  logic [7:0] wlog_addr [0:1023];
  logic [7:0] wlog_data [0:1023];
  int         wlog_cyc  [0:1023];

  boot_loader #(
    .SYNC_BYTE      (8'hA5),
    .ADDR_WIDTH     (8),
    .DATA_WIDTH     (8),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_ready     (rx_ready),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .core_run     (core_run),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (imem_we) begin
      wlog_addr[wn] <= imem_addr;
      wlog_data[wn] <= imem_wdata;
      wlog_cyc[wn]  <= cyc;
      wn            <= wn + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0;
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_reset();
    rx_valid = 1'b0;
    reset    = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rx_ready"}, {31'd0, rx_ready}, 32'd1);
    chk({tag, "_we"},       {31'd0, imem_we}, 32'd0);
    chk({tag, "_addr"},     {24'd0, imem_addr}, 32'd0);
    chk({tag, "_wdata"},    {24'd0, imem_wdata}, 32'd0);
    chk({tag, "_run"},      {31'd0, core_run}, 32'd0);
    chk({tag, "_error"},    {31'd0, error}, 32'd0);
    chk({tag, "_words"},    {23'd0, words_loaded}, 32'd0);
  endtask

  initial begin
    int base;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    reset    = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    chk_reset_outputs("por");

    // Basic back-to-back frame.
    base = wn;
    send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33);
    chk("t1_run_before_csum", {31'd0, core_run}, 32'd0);
    send(8'h66);
    chk("t1_nwrites", wn - base, 3);
    chk("t1_w0", {wlog_addr[base], wlog_data[base]}, 32'h0011);
    chk("t1_w1", {wlog_addr[base+1], wlog_data[base+1]}, 32'h0122);
    chk("t1_w2", {wlog_addr[base+2], wlog_data[base+2]}, 32'h0233);
    chk("t1_consecutive", wlog_cyc[base+2] - wlog_cyc[base], 2);
    chk("t1_run", {31'd0, core_run}, 32'd1);
    chk("t1_words", {23'd0, words_loaded}, 32'd3);
    chk("t1_rx_ready", {31'd0, rx_ready}, 32'd0);
    chk("t1_error", {31'd0, error}, 32'd0);
    // Bytes offered while running are ignored.
    base = wn;
    send(8'hA5); idle(1); send(8'h02); idle(1); send(8'h07); idle(2);
    chk("run_nwrites", wn - base, 0);
    chk("run_hold", {31'd0, core_run}, 32'd1);
    chk("run_words", {23'd0, words_loaded}, 32'd3);

    // Bad checksum then recovery.
    do_reset();
    base = wn;
    send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h67);
    chk("t2_nwrites", wn - base, 3);
    chk("t2_error", {31'd0, error}, 32'd1);
    chk("t2_run", {31'd0, core_run}, 32'd0);
    send(8'h12);
    chk("t2_err_sticky", {31'd0, error}, 32'd1);
    send(8'hA5);
    chk("t2_err_cleared", {31'd0, error}, 32'd0);
    base = wn;
    send(8'h01); send(8'hFF); send(8'hFF);
    chk("t2_rec_run", {31'd0, core_run}, 32'd1);
    chk("t2_rec_w", {wlog_addr[base], wlog_data[base]}, 32'h00FF);
    chk("t2_rec_words", {23'd0, words_loaded}, 32'd1);

    // Full 256-byte image.
    do_reset();
    base = wn;
    send(8'hA5); send(8'h00);
    for (int i = 0; i < 256; i++) send(8'h01);
    chk("t3_pre_run", {31'd0, core_run}, 32'd0);
    send(8'h00);
    chk("t3_nwrites", wn - base, 256);
    chk("t3_first", {wlog_addr[base], wlog_data[base]}, 32'h0001);
    chk("t3_last", {wlog_addr[base+255], wlog_data[base+255]}, 32'hFF01);
    chk("t3_words", {23'd0, words_loaded}, 32'd256);
    chk("t3_run", {31'd0, core_run}, 32'd1);

    // Leading junk, then stall until timeout.
    do_reset();
    base = wn;
    send(8'h00); send(8'h7E); send(8'hA5); send(8'h01); send(8'h10);
    idle(TIMEOUT - 1);
    chk("t4_before_expiry", {31'd0, error}, 32'd0);
    idle(1);
    chk("t4_expired", {31'd0, error}, 32'd1);
    chk("t4_run", {31'd0, core_run}, 32'd0);
    chk("t4_nwrites", wn - base, 1);
    chk("t4_w0", {wlog_addr[base], wlog_data[base]}, 32'h0010);
    chk("t4_words", {23'd0, words_loaded}, 32'd1);

    // Reset mid-DATA, then a clean load.
    do_reset();
    send(8'hA5); send(8'h04); send(8'h01); send(8'h02);
    chk("t5_words_mid", {23'd0, words_loaded}, 32'd2);
    do_reset();
    chk_reset_outputs("t5_rst");
    base = wn;
    send(8'hA5); send(8'h02); send(8'h0A); send(8'h0B); send(8'h15);
    chk("t5_run", {31'd0, core_run}, 32'd1);
    chk("t5_nwrites", wn - base, 2);
    chk("t5_w1", {wlog_addr[base+1], wlog_data[base+1]}, 32'h010B);
    chk("t5_words", {23'd0, words_loaded}, 32'd2);

    // Throttled payload.
    do_reset();
    base = wn;
    send(8'hA5); send(8'h04);
    send(8'h01); idle(1); send(8'h02); idle(1); send(8'h03); idle(1); send(8'h04); idle(1);
    chk("t6_nwrites", wn - base, 4);
    chk("t6_w3", {wlog_addr[base+3], wlog_data[base+3]}, 32'h0304);
    chk("t6_spacing", wlog_cyc[base+3] - wlog_cyc[base], 6);
    send(8'h0A);
    chk("t6_run", {31'd0, core_run}, 32'd1);
    base = wn;
    send(8'hA5); idle(1); send(8'hA5); idle(1);
    chk("t6_run_nwrites", wn - base, 0);
    chk("t6_run_hold", {31'd0, core_run}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
